// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network layer datapath: address-generator FSM
// states, default layer dimensions and the weight stride derivation.
package nn_pkg;

   typedef enum logic [1:0] {
      AG_IDLE = 2'd0,
      AG_RUN  = 2'd1,
      AG_DONE = 2'd2
   } ag_state_e;

   // Default layer dimensions, also used by the neuron ALU and the memories.
   localparam int unsigned NN_N_INPUTS  = 4;
   localparam int unsigned NN_N_NEURONS = 3;
   localparam int unsigned NN_IN_AW     = 4;
   localparam int unsigned NN_W_AW      = 8;
   localparam int unsigned NN_W_BASE    = 0;

   // Weight words per neuron: one per input, plus one bias word when enabled.
   function automatic int unsigned ag_stride(input int unsigned n_inputs, input bit bias_en);
      return bias_en ? n_inputs + 1 : n_inputs;
   endfunction

endpackage

// File: rtl/nn_idx_counter.sv
// Wrap counter 0..MaxCnt-1 with enable, synchronous clear and terminal-count flag.
module nn_idx_counter #(
   parameter int unsigned MaxCnt = 4,
   parameter int unsigned Width  = 2
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [Width-1:0] cnt_o,
   output logic             tc_o
);

   localparam logic [Width-1:0] LastVal = Width'(MaxCnt - 1);

   logic [Width-1:0] cnt_q, cnt_d;

   assign tc_o  = (cnt_q == LastVal);
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tc_o ? '0 : cnt_q + Width'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/nn_addr_gen.sv
// Fully-connected layer address generator: walks every (neuron, input) pair and issues
// input/weight read addresses with first/last framing. Define AG_BIAS_EN for a bias word.
module nn_addr_gen
   import nn_pkg::*;
#(
   parameter int unsigned N_INPUTS  = NN_N_INPUTS,
   parameter int unsigned N_NEURONS = NN_N_NEURONS,
   parameter int unsigned IN_AW     = NN_IN_AW,
   parameter int unsigned W_AW      = NN_W_AW,
   parameter int unsigned W_BASE    = NN_W_BASE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ag_rst,
   input  logic             ag_read,
   output logic [IN_AW-1:0] in_addr,
   output logic [W_AW-1:0]  w_addr,
   output logic             addr_valid,
   output logic             first,
   output logic             last,
   output logic             is_bias,
   output logic [7:0]       neuron_idx,
   output logic             done
);

`ifdef AG_BIAS_EN
   localparam bit BiasEn = 1'b1;
`else
   localparam bit BiasEn = 1'b0;
`endif

   localparam int unsigned STRIDE = ag_stride(N_INPUTS, BiasEn);
   localparam int unsigned IW     = $clog2(STRIDE);

   ag_state_e state_q;

   logic [IW-1:0]    i_cnt;
   logic [7:0]       n_cnt;
   logic             i_tc, n_tc;
   logic             clr, issue, final_elem, elem_bias;
   logic [IN_AW-1:0] in_nxt;
   logic [W_AW-1:0]  w_nxt;
   logic [31:0]      w_sum;

   logic [IN_AW-1:0] in_addr_q;
   logic [W_AW-1:0]  w_addr_q;
   logic             addr_valid_q, first_q, last_q, is_bias_q, done_q;
   logic [7:0]       neuron_idx_q;

   assign clr        = reset | ag_rst;
   assign issue      = ag_read & ~clr & (state_q != AG_DONE);
   assign final_elem = i_tc & n_tc;

   nn_idx_counter #(
      .MaxCnt (STRIDE),
      .Width  (IW)
   ) u_i_cnt (
      .clk_i (clk),
      .clr_i (clr),
      .en_i  (issue),
      .cnt_o (i_cnt),
      .tc_o  (i_tc)
   );

   // The neuron counter never wraps: its final element sends the FSM to DONE instead.
   nn_idx_counter #(
      .MaxCnt (N_NEURONS),
      .Width  (8)
   ) u_n_cnt (
      .clk_i (clk),
      .clr_i (clr),
      .en_i  (issue & i_tc & ~n_tc),
      .cnt_o (n_cnt),
      .tc_o  (n_tc)
   );

   always_comb begin
      elem_bias = BiasEn && (i_cnt == IW'(N_INPUTS));
      in_nxt    = elem_bias ? IN_AW'(N_INPUTS - 1) : IN_AW'(i_cnt);
      w_sum     = W_BASE + STRIDE * 32'(n_cnt) + 32'(i_cnt);
      w_nxt     = W_AW'(w_sum);
   end

   always_ff @(posedge clk) begin
      if (reset || ag_rst) begin
         state_q      <= AG_IDLE;
         in_addr_q    <= '0;
         w_addr_q     <= '0;
         addr_valid_q <= 1'b0;
         first_q      <= 1'b0;
         last_q       <= 1'b0;
         is_bias_q    <= 1'b0;
         neuron_idx_q <= '0;
         done_q       <= 1'b0;
      end else begin
         addr_valid_q <= 1'b0;
         first_q      <= 1'b0;
         last_q       <= 1'b0;
         is_bias_q    <= 1'b0;
         unique case (state_q)
            AG_IDLE, AG_RUN: begin
               if (ag_read) begin
                  in_addr_q    <= in_nxt;
                  w_addr_q     <= w_nxt;
                  addr_valid_q <= 1'b1;
                  first_q      <= (i_cnt == '0);
                  last_q       <= i_tc;
                  is_bias_q    <= elem_bias;
                  neuron_idx_q <= n_cnt;
                  state_q      <= final_elem ? AG_DONE : AG_RUN;
               end
            end
            AG_DONE: begin
               done_q <= 1'b1;
            end
            default: begin
               state_q <= AG_IDLE;
            end
         endcase
      end
   end

   assign in_addr    = in_addr_q;
   assign w_addr     = w_addr_q;
   assign addr_valid = addr_valid_q;
   assign first      = first_q;
   assign last       = last_q;
   assign is_bias    = is_bias_q;
   assign neuron_idx = neuron_idx_q;
   assign done       = done_q;

endmodule

// File: doc/nn_addr_gen.md
Name: nn_addr_gen

Overview:
- Address generator driven by the network control FSM's AG_rst / AG_read strobes.
- Walks every (neuron, input) pair of one fully-connected layer.
- Issues input-memory and weight-memory read addresses, one element per enabled cycle, with first/last framing for the neuron ALU.
- Asserts a sticky done once the layer is exhausted.

Parameters:
- N_INPUTS, 4, inputs per neuron (≥2).
- N_NEURONS, 3, neurons in the layer (≥1).
- IN_AW, 4, input address width; must hold N_INPUTS-1.
- W_AW, 8, weight address width; must hold W_BASE + N_NEURONS*STRIDE - 1.
- W_BASE, 0, weight-memory base address of neuron 0.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ag_rst  in  1  synchronous restart from control unit; priority over ag_read
- ag_read  in  1  advance-enable from control unit
- in_addr  out  IN_AW  input-memory address
- w_addr  out  W_AW  weight-memory address
- addr_valid  out  1  addresses valid this cycle
- first  out  1  element is input 0 of a neuron
- last  out  1  element is final element of a neuron
- is_bias  out  1  element is bias word (0 when feature disabled)
- neuron_idx  out  8  neuron of current element
- done  out  1  layer complete, sticky

Behaviour:
- Reset and ag_rst act identically and synchronously:
  - state=IDLE, counters i=0, n=0.
  - All outputs 0 on the next cycle.
- STRIDE = N_INPUTS, or N_INPUTS+1 with AG_BIAS_EN.
- All outputs are registered. An issued element appears one cycle after the edge sampling ag_read=1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - addr_valid=0.
  - ag_read=1 → issue element (0,0) and go to RUN.
  - ag_read=0 → stay.
- RUN, ag_read=1, issue element (n,i):
  - in_addr=i.
  - w_addr = W_BASE + n*STRIDE + i, computed at W_AW width; the multiply is a constant.
  - first=(i==0), last=(element is final of neuron), neuron_idx=n, addr_valid=1.
  - i advances; past the final element i→0 and n advances.
  - If the final element of neuron N_NEURONS-1 is issued, go to DONE.
- RUN, ag_read=0:
  - addr_valid=0, first=0, last=0.
  - Addresses and counters hold, no skipping or repeating.
  - The next ag_read resumes at the held position.
- DONE:
  - done=1 from the cycle after the final element; addr_valid=0.
  - ag_read is ignored.
  - Only reset/ag_rst leave DONE, to IDLE with done=0.
- Simultaneous ag_rst and ag_read: ag_rst wins and no element is issued.
- ag_rst mid-layer: the in-flight sequence is aborted. The next cycle shows addr_valid=0, and the next ag_read restarts at (0,0).
- A control pattern of ag_rst=1 with ag_read=1 is a restart, not a read.
- Counter wrap:
  - i wraps at STRIDE-1 exactly.
  - n never wraps; n==N_NEURONS-1 at its final element forces DONE.
- N_NEURONS=1: DONE is entered after N_INPUTS (or STRIDE) elements.

Optional Feature:
- Macro: AG_BIAS_EN.
- Defined:
  - Each neuron gets one extra element after input N_INPUTS-1.
  - On that element: w_addr = W_BASE + n*STRIDE + N_INPUTS, in_addr holds N_INPUTS-1, is_bias=1, last=1.
  - The preceding input element has last=0.
- Undefined:
  - STRIDE=N_INPUTS and is_bias is tied 0.
  - last marks input N_INPUTS-1.
- Port list is identical in both builds.

Decomposition:
- Shared package nn_pkg holds:
  - FSM state encoding (AG_IDLE, AG_RUN, AG_DONE).
  - STRIDE derivation function.
  - The default layer dimension constants also used by the ALU and memories.
- One sub-module, nn_idx_counter: a parameterised wrap counter with enable, synchronous clear, and a terminal-count output. It is instantiated twice, for i and for n, chained via terminal count.
- The FSM and output registers stay in the top.

Test Plan (N_INPUTS=4, N_NEURONS=3, W_BASE=16, bias off unless stated):
- reset 2 cycles, then ag_read=1 continuously → 12 valid beats.
  - in_addr 0,1,2,3 repeating; w_addr 16..27.
  - first on beats 1,5,9; last on beats 4,8,12; neuron_idx 0,0,0,0,1,…
  - done=1 the cycle after beat 12, and addr_valid=0 thereafter.
- ag_read toggled 1,0,1,0… → valid beats only on the cycles after ag_read=1; the w_addr sequence is still 16..27 with no gaps or repeats.
- ag_rst pulsed after beat 6 (w_addr=21), then ag_read=1 → next beat is in_addr=0, w_addr=16, first=1, done=0.
- ag_rst=1 and ag_read=1 together for 3 cycles → addr_valid stays 0 and no counter movement; the next ag_read alone gives w_addr=16.
- In DONE, ag_read=1 for 5 cycles → done holds 1, addr_valid 0; after ag_rst, done=0.
- AG_BIAS_EN, ag_read continuous → 15 beats.
  - w_addr 16..30.
  - Beats 5,10,15: is_bias=1, last=1, in_addr=3.
  - Beat 4 has last=0.
